// File: rtl/register_file_param.sv
// Parameterised register file: two registered read ports with optional write bypass,
// a never-bypassed debug read port, optional hardwired zero entry and a sequential clear engine.
module register_file_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] RS_addr,
  input  logic [ADDR_WIDTH-1:0] RT_addr,
  output logic [DATA_WIDTH-1:0] RS_data,
  output logic [DATA_WIDTH-1:0] RT_data,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  WriteEnable,
  input  logic                  clear_start,
  output logic                  busy,
  output logic                  write_dropped,
  input  logic [ADDR_WIDTH-1:0] read_address_debug,
  output logic [DATA_WIDTH-1:0] data_out_debug
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  typedef struct packed {
    logic                  en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [0:0]                       state;
  logic [ADDR_WIDTH-1:0]            clr_cnt;
  logic                             wr_to_zero;
  wr_req_t                          wr;

  assign wr_to_zero = (ZERO_REG != 0) && (write_address == '0);

  // Single effective write per cycle: the clear engine owns the port while running.
  always_comb begin
    wr = '0;
    if (state == ST_CLEAR) begin
      wr.en   = 1'b1;
      wr.addr = clr_cnt;
      wr.data = '0;
    end else if (WriteEnable && !wr_to_zero) begin
      wr.en   = 1'b1;
      wr.addr = write_address;
      wr.data = data_in;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] rd_sel(input logic [ADDR_WIDTH-1:0] a,
                                                   input logic byp);
    if ((ZERO_REG != 0) && (a == '0)) return '0;
    if (byp && (BYPASS != 0) && wr.en && (wr.addr == a)) return wr.data;
    return mem[a];
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) mem <= '0;
    else if (wr.en) mem[wr.addr] <= wr.data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      RS_data        <= '0;
      RT_data        <= '0;
      data_out_debug <= '0;
    end else begin
      RS_data        <= rd_sel(RS_addr, 1'b1);
      RT_data        <= rd_sel(RT_addr, 1'b1);
      data_out_debug <= rd_sel(read_address_debug, 1'b0);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= ST_IDLE;
      clr_cnt       <= '0;
      busy          <= 1'b0;
      write_dropped <= 1'b0;
    end else begin
      write_dropped <= (state == ST_CLEAR) && WriteEnable && !wr_to_zero;
      case (state)
        ST_IDLE: begin
          if (clear_start) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        default: begin
          // Terminal compare instead of wrap so busy spans exactly DEPTH cycles.
          if (clr_cnt == {ADDR_WIDTH{1'b1}}) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
            busy    <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_register_file_param.sv
// Scoreboard bench: two instances (zero-reg+bypass, plain+no-bypass) share stimulus;
// expected outputs are queued at drive time and popped after each clock edge.
module tb_register_file_param;
  logic        clock, reset;
  logic [4:0]  RS_addr, RT_addr, write_address, read_address_debug;
  logic [31:0] data_in;
  logic        WriteEnable, clear_start;
  logic [31:0] rs_a, rt_a, dbg_a, rs_b, rt_b, dbg_b;
  logic        busy_a, busy_b, wd_a, wd_b;

  register_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
    .clock(clock), .reset(reset), .RS_addr(RS_addr), .RT_addr(RT_addr),
    .RS_data(rs_a), .RT_data(rt_a), .write_address(write_address), .data_in(data_in),
    .WriteEnable(WriteEnable), .clear_start(clear_start), .busy(busy_a),
    .write_dropped(wd_a), .read_address_debug(read_address_debug), .data_out_debug(dbg_a));

  register_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(0)) u_dut_b (
    .clock(clock), .reset(reset), .RS_addr(RS_addr), .RT_addr(RT_addr),
    .RS_data(rs_b), .RT_data(rt_b), .write_address(write_address), .data_in(data_in),
    .WriteEnable(WriteEnable), .clear_start(clear_start), .busy(busy_b),
    .write_dropped(wd_b), .read_address_debug(read_address_debug), .data_out_debug(dbg_b));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rsa, rta, dbga, rsb, rtb, dbgb;
    logic        busy, wda, wdb;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] ma[32], mb[32];
  bit          m_clear;
  int          m_cnt;
  int          n_vec, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Predict next-cycle outputs from the model, advance the model, clock, then compare.
  task automatic step();
    exp_t        e;
    logic        wa_en, wb_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    w_addr = m_clear ? 5'(m_cnt) : write_address;
    w_data = m_clear ? 32'h0 : data_in;
    wa_en  = m_clear || (WriteEnable && write_address != 5'd0);
    wb_en  = m_clear || WriteEnable;
    if (!reset) begin
      e = '{default: '0};
      for (int i = 0; i < 32; i++) begin ma[i] = 0; mb[i] = 0; end
      m_clear = 0;
      m_cnt   = 0;
    end else begin
      e.rsa  = (RS_addr == 0) ? 32'h0 : (wa_en && w_addr == RS_addr) ? w_data : ma[RS_addr];
      e.rta  = (RT_addr == 0) ? 32'h0 : (wa_en && w_addr == RT_addr) ? w_data : ma[RT_addr];
      e.dbga = (read_address_debug == 0) ? 32'h0 : ma[read_address_debug];
      e.rsb  = mb[RS_addr];
      e.rtb  = mb[RT_addr];
      e.dbgb = mb[read_address_debug];
      e.wda  = m_clear && WriteEnable && write_address != 5'd0;
      e.wdb  = m_clear && WriteEnable;
      e.busy = m_clear ? (m_cnt != 31) : clear_start;
      if (wa_en) ma[w_addr] = w_data;
      if (wb_en) mb[w_addr] = w_data;
      if (m_clear) begin
        if (m_cnt == 31) begin m_clear = 0; m_cnt = 0; end
        else m_cnt++;
      end else if (clear_start) begin
        m_clear = 1;
        m_cnt   = 0;
      end
    end
    sbq.push_back(e);
    @(posedge clock);
    #1;
    e = sbq.pop_front();
    chk("rs_a", rs_a, e.rsa);
    chk("rt_a", rt_a, e.rta);
    chk("dbg_a", dbg_a, e.dbga);
    chk("rs_b", rs_b, e.rsb);
    chk("rt_b", rt_b, e.rtb);
    chk("dbg_b", dbg_b, e.dbgb);
    chk("busy_a", 32'(busy_a), 32'(e.busy));
    chk("busy_b", 32'(busy_b), 32'(e.busy));
    chk("wd_a", 32'(wd_a), 32'(e.wda));
    chk("wd_b", 32'(wd_b), 32'(e.wdb));
  endtask

  task automatic idle_in();
    WriteEnable = 0; clear_start = 0; write_address = 0; data_in = 0;
  endtask

  initial begin
    int busy_cnt;
    n_vec = 0; n_err = 0; m_clear = 0; m_cnt = 0;
    for (int i = 0; i < 32; i++) begin ma[i] = 'x; mb[i] = 'x; end
    idle_in();
    RS_addr = 0; RT_addr = 0; read_address_debug = 0;
    reset = 0;
    @(negedge clock);
    step();
    reset = 1;

    // all entries read zero after reset
    for (int i = 0; i < 32; i++) begin
      RS_addr = 5'(i); RT_addr = 5'(31 - i); read_address_debug = 5'(i);
      step();
    end

    // plain write then read
    WriteEnable = 1; write_address = 5; data_in = 32'hDEADBEEF;
    step();
    idle_in(); RS_addr = 5;
    step();
    chk("rs_a_deadbeef", rs_a, 32'hDEADBEEF);

    // same-cycle write/read: bypass vs old value, debug never bypassed
    WriteEnable = 1; write_address = 7; data_in = 32'h12345678;
    RT_addr = 7; read_address_debug = 7;
    step();
    chk("rt_a_bypass", rt_a, 32'h12345678);
    chk("rt_b_nobypass", rt_b, 32'h0);
    chk("dbg_a_prewrite", dbg_a, 32'h0);
    idle_in();
    step();

    // write to entry 0
    WriteEnable = 1; write_address = 0; data_in = 32'hFFFFFFFF;
    RS_addr = 0; RT_addr = 0; read_address_debug = 0;
    step();
    idle_in();
    step();
    chk("rs_a_zero_reg", rs_a, 32'h0);
    chk("rs_b_entry0", rs_b, 32'hFFFFFFFF);

    // fill, then clear with a dropped write and an ignored restart
    for (int i = 0; i < 32; i++) begin
      WriteEnable = 1; write_address = 5'(i); data_in = $urandom;
      RS_addr = 5'($urandom); RT_addr = 5'($urandom); read_address_debug = 5'($urandom);
      step();
    end
    idle_in(); clear_start = 1;
    step();
    busy_cnt = busy_a ? 1 : 0;
    clear_start = 0;
    for (int c = 1; c < 40; c++) begin
      idle_in();
      RS_addr = 5'($urandom); RT_addr = 5'(c); read_address_debug = 5'($urandom);
      if (c == 5) clear_start = 1;
      if (c == 10) begin WriteEnable = 1; write_address = 3; data_in = 32'hCAFEF00D; end
      step();
      if (c == 10) begin
        chk("wd_a_pulse", 32'(wd_a), 32'h1);
      end
      if (c == 11) chk("wd_a_one_cycle", 32'(wd_a), 32'h0);
      if (busy_a) busy_cnt++;
    end
    chk("busy_cycles", 32'(busy_cnt), 32'd32);
    for (int i = 0; i < 32; i++) begin
      RS_addr = 5'(i); RT_addr = 5'(i); read_address_debug = 5'(i);
      step();
      chk("cleared_b", rs_b, 32'h0);
    end

    // reset in the middle of a clear
    for (int i = 0; i < 8; i++) begin
      WriteEnable = 1; write_address = 5'(i + 16); data_in = $urandom;
      step();
    end
    idle_in(); clear_start = 1;
    step();
    clear_start = 0;
    for (int c = 0; c < 10; c++) step();
    reset = 0;
    step();
    chk("busy_after_reset", 32'(busy_a), 32'h0);
    reset = 1;
    WriteEnable = 1; write_address = 20; data_in = 32'hA5A5A5A5;
    step();
    idle_in(); RS_addr = 20; RT_addr = 18; read_address_debug = 20;
    step();
    chk("rs_a_after_reset", rs_a, 32'hA5A5A5A5);

    // random traffic with occasional clears
    for (int k = 0; k < 300; k++) begin
      WriteEnable = ($urandom_range(0, 2) != 0);
      write_address = 5'($urandom); data_in = $urandom;
      clear_start = ($urandom_range(0, 60) == 0);
      RS_addr = ($urandom_range(0, 3) == 0) ? write_address : 5'($urandom);
      RT_addr = ($urandom_range(0, 3) == 0) ? write_address : 5'($urandom);
      read_address_debug = ($urandom_range(0, 3) == 0) ? write_address : 5'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
